// File: rtl/snake_if.sv
// Button inputs and game-state bus shared by the snake engine and its display side.
interface snake_if;
  logic         up;
  logic         down;
  logic         left;
  logic         right;
  logic [487:0] snake_data;

  modport master (input up, input down, input left, input right, output snake_data);
  modport slave  (output up, output down, output left, output right, input snake_data);
endinterface

// File: rtl/snake_game_engine.sv
// Snake 1 game-state engine: button sync, stage FSM, tick-driven movement with a
// segment walk for self-collision, apple/hearts bookkeeping and the packed display bus.
module snake_game_engine #(
  parameter int TICK_DIV    = 2_500_000,
  parameter int HEART_TICKS = 5,
  parameter int LEN_INIT    = 3,
  parameter int LEN_MAX     = 49
) (
  input logic     iVGA_CLK,
  input logic     iRST_n,
  snake_if.master bus
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int HB_W  = $clog2(HEART_TICKS + 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [HB_W-1:0]  HEART_TOP = HB_W'(HEART_TICKS);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd2, ST_OVER = 2'd3} stage_e;
  typedef enum logic [1:0] {MV_WAIT = 2'd0, MV_WALK = 2'd1, MV_COMMIT = 2'd2} mv_e;

  // Direction codes double as movement headings: 00 up, 01 right, 10 down, 11 left.
  function automatic logic [10:0] step_pos(input logic [10:0] pos, input logic [1:0] code);
    case (code)
      2'b00:   step_pos = pos - 11'd40;
      2'b01:   step_pos = pos + 11'd1;
      2'b10:   step_pos = pos + 11'd40;
      2'b11:   step_pos = pos - 11'd1;
      default: step_pos = pos;
    endcase
  endfunction

  function automatic logic [10:0] relocate(input logic [10:0] v);
    relocate = (v < 11'd1600) ? v : (v - 11'd1600);
  endfunction

  function automatic logic [99:0] init_entries();
    logic [99:0] e;
    e = 100'd0;
    for (int k = 0; k < 50; k++) begin
      e[2*k +: 2] = (k < LEN_INIT) ? 2'b11 : 2'b00;
    end
    return e;
  endfunction

  localparam logic [99:0] ENTRIES_INIT = init_entries();

  logic [3:0]       btn_meta_r, btn_sync_r;
  logic             any_prev_r;
  stage_e           stage_r, stage_nxt_s;
  mv_e              mv_r, mv_nxt_s;
  logic [CNT_W-1:0] tick_cnt_r;
  logic [HB_W-1:0]  heart_cnt_r;
  logic [15:0]      lfsr_r;
  logic [99:0]      entries_r;
  logic [10:0]      head_r, apple_r, next_head_r, cursor_r;
  logic [5:0]       row_r, col_r, next_row_r, next_col_r;
  logic [5:0]       len_r, limit_r, j_r;
  logic [6:0]       hearts_r;
  logic [1:0]       heading_r, last_dir_r, move_dir_r, req_dir_s;
  logic             eat_r, self_hit_r;
  logic             press_s, tick_s, wall_s, heart_wrap_s, hearts_empty_s;
  logic             init_s, start_s, commit_s;
  logic [10:0]      nhead_s;
  logic [5:0]       nrow_s, ncol_s, j_inc_s;

  assign press_s        = (|btn_sync_r) & ~any_prev_r;
  assign tick_s         = (stage_r == ST_PLAY) && (tick_cnt_r == TICK_LAST);
  assign heart_wrap_s   = (heart_cnt_r + HB_W'(1)) == HEART_TOP;
  assign hearts_empty_s = !eat_r && heart_wrap_s && (hearts_r == 7'd1);
  assign j_inc_s        = j_r + 6'd1;

  // Requested heading from the synchronized buttons, up > down > left > right.
  always_comb begin
    req_dir_s = 2'b01;
    if (btn_sync_r[3]) begin
      req_dir_s = 2'b00;
    end else if (btn_sync_r[2]) begin
      req_dir_s = 2'b10;
    end else if (btn_sync_r[1]) begin
      req_dir_s = 2'b11;
    end else begin
      req_dir_s = 2'b01;
    end
  end

  // Next head position and wall test for the current heading.
  always_comb begin
    nhead_s = head_r;
    nrow_s  = row_r;
    ncol_s  = col_r;
    wall_s  = 1'b0;
    case (heading_r)
      2'b00:   begin wall_s = (row_r == 6'd0);  nrow_s = row_r - 6'd1; end
      2'b01:   begin wall_s = (col_r == 6'd39); ncol_s = col_r + 6'd1; end
      2'b10:   begin wall_s = (row_r == 6'd39); nrow_s = row_r + 6'd1; end
      2'b11:   begin wall_s = (col_r == 6'd0);  ncol_s = col_r - 6'd1; end
      default: wall_s = 1'b0;
    endcase
    nhead_s = step_pos(head_r, heading_r);
  end

  // Stage and movement next-state logic with control strobes.
  always_comb begin
    stage_nxt_s = stage_r;
    mv_nxt_s    = mv_r;
    init_s      = 1'b0;
    start_s     = 1'b0;
    commit_s    = 1'b0;
    case (stage_r)
      ST_IDLE: begin
        mv_nxt_s = MV_WAIT;
        if (press_s) begin
          stage_nxt_s = ST_PLAY;
          init_s      = 1'b1;
        end else begin
          stage_nxt_s = ST_IDLE;
        end
      end
      ST_PLAY: begin
        case (mv_r)
          MV_WAIT: begin
            if (tick_s && wall_s) begin
              stage_nxt_s = ST_OVER;
            end else if (tick_s) begin
              mv_nxt_s = MV_WALK;
              start_s  = 1'b1;
            end else begin
              mv_nxt_s = MV_WAIT;
            end
          end
          MV_WALK: begin
            if (j_inc_s == limit_r) begin
              mv_nxt_s = MV_COMMIT;
            end else begin
              mv_nxt_s = MV_WALK;
            end
          end
          MV_COMMIT: begin
            mv_nxt_s = MV_WAIT;
            if (self_hit_r) begin
              stage_nxt_s = ST_OVER;
            end else begin
              commit_s    = 1'b1;
              stage_nxt_s = hearts_empty_s ? ST_OVER : ST_PLAY;
            end
          end
          default: mv_nxt_s = MV_WAIT;
        endcase
      end
      ST_OVER: begin
        mv_nxt_s = MV_WAIT;
        if (press_s) begin
          stage_nxt_s = ST_IDLE;
        end else begin
          stage_nxt_s = ST_OVER;
        end
      end
      default: begin
        stage_nxt_s = ST_IDLE;
        mv_nxt_s    = MV_WAIT;
      end
    endcase
  end

  // Button synchronizer, press edge history and LFSR.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      btn_meta_r <= 4'd0;
      btn_sync_r <= 4'd0;
      any_prev_r <= 1'b0;
      lfsr_r     <= 16'hACE1;
    end else begin
      btn_meta_r <= {bus.up, bus.down, bus.left, bus.right};
      btn_sync_r <= btn_meta_r;
      any_prev_r <= |btn_sync_r;
      lfsr_r     <= {lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5], lfsr_r[15:1]};
    end
  end

  // State registers and the movement tick / heart counters.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      stage_r     <= ST_IDLE;
      mv_r        <= MV_WAIT;
      tick_cnt_r  <= '0;
      heart_cnt_r <= '0;
    end else begin
      stage_r <= stage_nxt_s;
      mv_r    <= mv_nxt_s;
      if (init_s) begin
        tick_cnt_r  <= '0;
        heart_cnt_r <= '0;
      end else begin
        if (stage_r == ST_PLAY) begin
          tick_cnt_r <= tick_s ? '0 : tick_cnt_r + CNT_W'(1);
        end
        if (commit_s && !eat_r) begin
          heart_cnt_r <= heart_wrap_s ? '0 : heart_cnt_r + HB_W'(1);
        end
      end
    end
  end

  // Heading latch; a reversal of the last committed move is refused.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      heading_r <= 2'b01;
    end else if (init_s) begin
      heading_r <= 2'b01;
    end else if ((stage_r == ST_PLAY) && (|btn_sync_r) && (req_dir_s != (last_dir_r ^ 2'b10))) begin
      heading_r <= req_dir_s;
    end
  end

  // Body walk: compare every visited segment against the pending head.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      next_head_r <= 11'd0;
      next_row_r  <= 6'd0;
      next_col_r  <= 6'd0;
      move_dir_r  <= 2'b01;
      eat_r       <= 1'b0;
      limit_r     <= 6'd0;
      cursor_r    <= 11'd0;
      j_r         <= 6'd0;
      self_hit_r  <= 1'b0;
    end else if (start_s) begin
      next_head_r <= nhead_s;
      next_row_r  <= nrow_s;
      next_col_r  <= ncol_s;
      move_dir_r  <= heading_r;
      eat_r       <= (nhead_s == apple_r);
      limit_r     <= len_r + {5'd0, (nhead_s == apple_r)};
      cursor_r    <= head_r;
      j_r         <= 6'd0;
      self_hit_r  <= 1'b0;
    end else if ((stage_r == ST_PLAY) && (mv_r == MV_WALK)) begin
      if (cursor_r == next_head_r) begin
        self_hit_r <= 1'b1;
      end
      cursor_r <= step_pos(cursor_r, entries_r[{j_r, 1'b0} +: 2]);
      j_r      <= j_inc_s;
    end
  end

  // Game state published on the bus; it only changes on init or a clean commit.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      entries_r  <= 100'd0;
      head_r     <= 11'd0;
      row_r      <= 6'd0;
      col_r      <= 6'd0;
      len_r      <= 6'd0;
      apple_r    <= 11'd425;
      hearts_r   <= 7'd0;
      last_dir_r <= 2'b01;
    end else if (init_s) begin
      entries_r  <= ENTRIES_INIT;
      head_r     <= 11'd810;
      row_r      <= 6'd20;
      col_r      <= 6'd10;
      len_r      <= 6'(LEN_INIT);
      apple_r    <= 11'd425;
      hearts_r   <= 7'd100;
      last_dir_r <= 2'b01;
    end else if (commit_s) begin
      head_r     <= next_head_r;
      row_r      <= next_row_r;
      col_r      <= next_col_r;
      entries_r  <= {entries_r[97:0], move_dir_r ^ 2'b10};
      last_dir_r <= move_dir_r;
      if (eat_r) begin
        len_r    <= (len_r == 6'(LEN_MAX)) ? len_r : len_r + 6'd1;
        hearts_r <= 7'd100;
        apple_r  <= relocate(lfsr_r[10:0]);
      end else if (heart_wrap_s) begin
        hearts_r <= hearts_r - 7'd1;
      end
    end
  end

  assign bus.snake_data = {
    {25'd0, hearts_r}, {21'd0, apple_r}, 32'd50, 32'd0, {30'd0, stage_r},
    32'd0, {26'd0, len_r}, 32'd0, {21'd0, head_r}, 100'd0, entries_r
  };

endmodule

// File: tb/tb_snake_game_engine.sv
// Directed bench: start, movement latency, reverse request, apple eat, wall hit,
// hearts exhaustion over a square loop, and stage transitions on presses.
module tb_snake_game_engine;
  localparam int TD = 64;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   t;
  int   lat;
  logic [487:0] exp_reset;

  snake_if bus ();

  snake_game_engine #(.TICK_DIV(TD), .HEART_TICKS(5), .LEN_INIT(3), .LEN_MAX(49)) dut (
    .iVGA_CLK(clk),
    .iRST_n  (rst_n),
    .bus     (bus)
  );

  wire [31:0] head_w  = bus.snake_data[231:200];
  wire [31:0] len_w   = bus.snake_data[295:264];
  wire [31:0] stage_w = bus.snake_data[359:328];
  wire [31:0] apple_w = bus.snake_data[455:424];
  wire [31:0] heart_w = bus.snake_data[487:456];
  wire [31:0] ent_w   = {24'd0, bus.snake_data[7:0]};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input logic [3:0] b);
    bus.up = b[3]; bus.down = b[2]; bus.left = b[1]; bus.right = b[0];
  endtask

  task automatic go_to(input int k);
    while (t < k) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic wait_stage(input logic [31:0] want, input int budget, output int k);
    k = 0;
    while (stage_w !== want && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("stage_wait", stage_w, want);
    t = 0;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; vectors = 0; miscompares = 0; t = 0;
    set_btn(4'b0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_reset = '0;
    exp_reset[423:392] = 32'd50;
    exp_reset[455:424] = 32'd425;
    vectors++;
    assert (bus.snake_data === exp_reset) else begin
      miscompares++;
      $error("FAIL reset_bus: observed %h expected %h", bus.snake_data, exp_reset);
    end

    // Start the game with a right pulse.
    set_btn(4'b0001);
    wait_stage(32'd2, 20, lat);
    chk("press_latency", lat, 32'd3);
    chk("init_head", head_w, 32'd810);
    chk("init_len", len_w, 32'd3);
    chk("init_entries", ent_w, 32'h3F);
    chk("init_hearts", heart_w, 32'd100);
    chk("init_apple", apple_w, 32'd425);
    set_btn(4'b0000);

    // First tick: bus changes exactly limit+2 = 5 cycles after the tick cycle.
    go_to(TD + 3);
    chk("move1_before", head_w, 32'd810);
    go_to(TD + 4);
    chk("move1_head", head_w, 32'd811);
    chk("move1_entries", ent_w, 32'hFF);

    // Left is the reverse of right and must be ignored.
    set_btn(4'b0010);
    go_to(2 * TD + 4);
    chk("reverse_ignored", head_w, 32'd812);

    // Ten moves up, twelve moves right, landing next to the apple.
    set_btn(4'b1000);
    go_to(12 * TD + 4);
    chk("up_head", head_w, 32'd412);
    chk("up_entry0", {30'd0, ent_w[1:0]}, 32'd2);
    set_btn(4'b0001);
    go_to(24 * TD + 4);
    chk("steer_head", head_w, 32'd424);
    chk("hearts_before_eat", heart_w, 32'd96);
    set_btn(4'b0000);
    go_to(25 * TD + 4);
    chk("eat_before", head_w, 32'd424);
    go_to(25 * TD + 5);
    chk("eat_head", head_w, 32'd425);
    chk("eat_len", len_w, 32'd4);
    chk("eat_hearts", heart_w, 32'd100);
    vectors++;
    assert (apple_w !== 32'd425 && apple_w < 32'd1600) else begin
      miscompares++;
      $error("FAIL apple_reloc: observed %0d expected !=425 and <1600", apple_w);
    end

    // Up to row 0, then the next tick is a wall hit.
    set_btn(4'b1000);
    go_to(35 * TD + 5);
    chk("row0_head", head_w, 32'd25);
    chk("row0_hearts", heart_w, 32'd98);
    go_to(36 * TD - 1);
    chk("wall_before", stage_w, 32'd2);
    go_to(36 * TD);
    chk("wall_stage", stage_w, 32'd3);
    chk("wall_head", head_w, 32'd25);

    set_btn(4'b0000);
    go_to(36 * TD + 6);
    set_btn(4'b1000);
    wait_stage(32'd0, 20, lat);
    chk("over_to_idle_latency", lat, 32'd3);

    // New game, circle a 10x10 square until the hearts timer runs out.
    set_btn(4'b0000);
    repeat (5) @(negedge clk);
    set_btn(4'b0001);
    wait_stage(32'd2, 20, lat);
    chk("restart_head", head_w, 32'd810);
    chk("restart_len", len_w, 32'd3);
    chk("restart_hearts", heart_w, 32'd100);
    chk("restart_apple", apple_w, 32'd425);
    for (int n = 1; n <= 500; n++) begin
      case (((n - 1) % 40) / 10)
        0:       set_btn(4'b0001);
        1:       set_btn(4'b0100);
        2:       set_btn(4'b0010);
        default: set_btn(4'b1000);
      endcase
      if (n == 500) begin
        go_to(n * TD + 3);
        chk("hearts_last_stage", stage_w, 32'd2);
        chk("hearts_last_value", heart_w, 32'd1);
      end
      go_to(n * TD + 4);
      if (n == 4)  chk("hearts_t4", heart_w, 32'd100);
      if (n == 5)  chk("hearts_t5", heart_w, 32'd99);
      if (n == 10) chk("square_right", head_w, 32'd820);
      if (n == 20) chk("square_down", head_w, 32'd1220);
      if (n == 40) chk("square_loop", head_w, 32'd810);
    end
    chk("hearts_zero", heart_w, 32'd0);
    chk("hearts_over", stage_w, 32'd3);

    set_btn(4'b0000);
    repeat (5) @(negedge clk);
    set_btn(4'b0100);
    wait_stage(32'd0, 20, lat);
    chk("final_idle", stage_w, 32'd0);
    set_btn(4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
